fifo_param: RTL and testbench
=============================

FIFO_PARAM -- requirements
Module: fifo_param

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 32, storage entries; power of two, >=4.
REQ-003 SHALL have parameter AF_LEVEL, default 28, almost_full asserts when count >= AF_LEVEL.
REQ-004 SHALL have parameter AE_LEVEL, default 4, almost_empty asserts when count <= AE_LEVEL.
REQ-005 SHALL have port clock, input, 1, sole clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port flush, input, 1, synchronous discard of all stored entries.
REQ-008 SHALL have port write, input, 1, write request.
REQ-009 SHALL have port datain, input, WIDTH, write data.
REQ-010 SHALL have port read, input, 1, read request.
REQ-011 SHALL have port dataout, output, WIDTH, registered read data.
REQ-012 SHALL have port dataout_valid, output, 1, high for one cycle when dataout carries a newly popped word.
REQ-013 SHALL have ports full, empty, almost_full, almost_empty, output, 1 each, registered status flags.
REQ-014 SHALL have port count, output, log2(DEPTH)+1, number of stored entries, 0..DEPTH.
REQ-015 SHALL have ports overflow, underflow, output, 1 each, sticky error flags.
REQ-016 SHALL have port clr_err, input, 1, clears overflow and underflow.

Function
REQ-017 SHALL accept a write (writeEn) when write=1 and (full=0 or readEn=1); stores datain at wPtr, wPtr increments modulo DEPTH.
REQ-018 SHALL accept a read (readEn) when read=1 and empty=0; pops entry at rPtr, rPtr increments modulo DEPTH.
REQ-019 SHALL present popped word on dataout the cycle after readEn (1-cycle latency) with dataout_valid=1 that same cycle.
REQ-020 SHALL hold dataout at its last value when no read is accepted; dataout_valid=0 then.
REQ-021 SHALL update count: +1 write only, -1 read only, unchanged on both or neither.
REQ-022 SHALL, when full and write and read both asserted, accept both; count stays DEPTH.
REQ-023 SHALL, when empty and write and read both asserted, accept write only; read rejected, no underflow, count becomes 1.
REQ-024 SHALL derive full, empty, almost_full, almost_empty from next-state count so every flag is exact in the cycle count updates; no combinational paths from inputs to outputs.
REQ-025 SHALL set overflow when write=1 is rejected (full, no read); set underflow when read=1 while empty; both stay set until clr_err or reset.
REQ-026 SHALL, when clr_err and a new error occur in the same cycle, leave the flag set.
REQ-027 SHALL, on flush=1, zero wPtr, rPtr, count next cycle; ignore write/read that cycle; dataout holds, dataout_valid=0; error flags unaffected.
REQ-028 SHALL wrap pointers from DEPTH-1 to 0 without data loss or flag glitch.
REQ-029 SHALL not require storage array reset; unread contents are don't-care.

Reset
REQ-030 SHALL, while reset=1 at a rising edge, set wPtr=0, rPtr=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0, dataout=0, dataout_valid=0, overflow=0, underflow=0.
REQ-031 SHALL give reset priority over flush, write, read and clr_err, including mid-operation; stored data is lost.
REQ-032 SHALL accept a write in the first cycle after reset deasserts.

Verification
REQ-033 SHALL check: reset, write 0x01..0x20 (32 words) -> full=1 after 32nd, count=32, almost_full from count 28; read all -> dataout 0x01..0x20 in order, each one cycle after read, empty=1 at end.
REQ-034 SHALL check: full, write+read same cycle with datain 0xAA -> count stays 32, dataout=0x01 next cycle, 0xAA read out last.
REQ-035 SHALL check: empty, write 0x5C + read same cycle -> count=1, no dataout_valid, underflow=0; next read returns 0x5C.
REQ-036 SHALL check: full, write 0x77 alone -> overflow=1, count=32, 0x77 never read; clr_err -> overflow=0; empty read -> underflow=1.
REQ-037 SHALL check: 40 interleaved writes/reads crossing the pointer wrap -> data order preserved, count exact every cycle.
REQ-038 SHALL check: count=10, flush -> count=0, empty=1 next cycle; reset asserted with count=5 -> all REQ-030 values next cycle.

Source files
------------

// File: rtl/fifo_param.sv
// Synchronous single-clock FIFO with registered read data, exact status flags
// derived from next-state count, and sticky overflow/underflow error flags.
module fifo_param #(
   parameter int WIDTH    = 8,
   parameter int DEPTH    = 32,
   parameter int AF_LEVEL = 28,
   parameter int AE_LEVEL = 4
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       write,
   input  logic [WIDTH-1:0]           datain,
   input  logic                       read,
   output logic [WIDTH-1:0]           dataout,
   output logic                       dataout_valid,
   output logic                       full,
   output logic                       empty,
   output logic                       almost_full,
   output logic                       almost_empty,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       overflow,
   output logic                       underflow,
   input  logic                       clr_err
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];
   localparam logic [AW:0] AF_C    = AF_LEVEL[AW:0];
   localparam logic [AW:0] AE_C    = AE_LEVEL[AW:0];
   localparam logic [AW:0] ONE_C   = (AW+1)'(1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
   logic [AW:0]      count_q, count_d;
   logic [WIDTH-1:0] dout_q;
   logic             dvld_q;
   logic             full_q, empty_q, afull_q, aempty_q;
   logic             ovf_q, ovf_d, udf_q, udf_d;
   logic             wr_en, rd_en;

   always_comb begin
      rd_en   = read & ~empty_q & ~flush;
      // a full FIFO still takes a write when a pop frees the slot this cycle
      wr_en   = write & (~full_q | rd_en) & ~flush;
      wptr_d  = wr_en ? wptr_q + AW'(1) : wptr_q;
      rptr_d  = rd_en ? rptr_q + AW'(1) : rptr_q;
      count_d = count_q;
      case ({wr_en, rd_en})
         2'b10:   count_d = count_q + ONE_C;
         2'b01:   count_d = count_q - ONE_C;
         default: count_d = count_q;
      endcase
      if (flush) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
      end
      // a read on empty alongside a write is not an error: the write lands
      ovf_d = (ovf_q & ~clr_err) | (~flush & write & full_q & ~rd_en);
      udf_d = (udf_q & ~clr_err) | (~flush & read & empty_q & ~write);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wptr_q   <= '0;
         rptr_q   <= '0;
         count_q  <= '0;
         dout_q   <= '0;
         dvld_q   <= 1'b0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
         afull_q  <= 1'b0;
         aempty_q <= 1'b1;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
      end else begin
         wptr_q   <= wptr_d;
         rptr_q   <= rptr_d;
         count_q  <= count_d;
         dvld_q   <= rd_en;
         if (rd_en) dout_q <= mem_q[rptr_q];
         full_q   <= (count_d == DEPTH_C);
         empty_q  <= (count_d == '0);
         afull_q  <= (count_d >= AF_C);
         aempty_q <= (count_d <= AE_C);
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
      end
   end

   // storage needs no reset; stale entries are never observable
   always_ff @(posedge clock) begin
      if (wr_en && !reset) mem_q[wptr_q] <= datain;
   end

   assign dataout       = dout_q;
   assign dataout_valid = dvld_q;
   assign full          = full_q;
   assign empty         = empty_q;
   assign almost_full   = afull_q;
   assign almost_empty  = aempty_q;
   assign count         = count_q;
   assign overflow      = ovf_q;
   assign underflow     = udf_q;

endmodule

// File: tb/tb_fifo_param.sv
// Directed bench for fifo_param: fill/drain, simultaneous ops at full/empty,
// error flags, pointer wrap, flush and mid-operation reset.
module tb_fifo_param;

   logic       clock = 1'b0;
   logic       reset, flush, write, read, clr_err;
   logic [7:0] datain;
   logic [7:0] dataout;
   logic       dataout_valid, full, empty, almost_full, almost_empty;
   logic [5:0] count;
   logic       overflow, underflow;

   int checks   = 0;
   int failures = 0;

   fifo_param #(.WIDTH(8), .DEPTH(32), .AF_LEVEL(28), .AE_LEVEL(4)) dut (
      .clock(clock), .reset(reset), .flush(flush), .write(write),
      .datain(datain), .read(read), .dataout(dataout),
      .dataout_valid(dataout_valid), .full(full), .empty(empty),
      .almost_full(almost_full), .almost_empty(almost_empty),
      .count(count), .overflow(overflow), .underflow(underflow),
      .clr_err(clr_err)
   );

   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      reset = 0; flush = 0; write = 0; read = 0; clr_err = 0; datain = 8'h00;
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, ".count"}, 32'(count), 0);
      chk({tag, ".empty"}, 32'(empty), 1);
      chk({tag, ".aempty"}, 32'(almost_empty), 1);
      chk({tag, ".full"}, 32'(full), 0);
      chk({tag, ".afull"}, 32'(almost_full), 0);
      chk({tag, ".dout"}, 32'(dataout), 0);
      chk({tag, ".dvld"}, 32'(dataout_valid), 0);
      chk({tag, ".ovf"}, 32'(overflow), 0);
      chk({tag, ".udf"}, 32'(underflow), 0);
   endtask

   task automatic fill32();
      for (int i = 1; i <= 32; i++) begin
         write = 1; datain = 8'(i);
         step();
      end
      write = 0;
      chk("fill.count", 32'(count), 32);
      chk("fill.full", 32'(full), 1);
   endtask

   initial begin
      int exp_cnt, rd_idx, wr_idx;
      logic rd_acc;
      idle();
      reset = 1;
      step(); step();
      chk_reset_state("rst");
      reset = 0;

      // fill 0x01..0x20, flags tracked each cycle
      for (int i = 1; i <= 32; i++) begin
         write = 1; datain = 8'(i);
         step();
         chk("wr.count", 32'(count), 32'(i));
         chk("wr.full", 32'(full), 32'(i == 32));
         chk("wr.afull", 32'(almost_full), 32'(i >= 28));
         chk("wr.aempty", 32'(almost_empty), 32'(i <= 4));
         chk("wr.empty", 32'(empty), 0);
      end
      write = 0;

      // drain, one-cycle latency
      for (int k = 1; k <= 32; k++) begin
         read = 1;
         step();
         chk("rd.dout", 32'(dataout), 32'(k));
         chk("rd.dvld", 32'(dataout_valid), 1);
         chk("rd.count", 32'(count), 32'(32 - k));
      end
      read = 0;
      chk("rd.empty", 32'(empty), 1);
      step();
      chk("hold.dvld", 32'(dataout_valid), 0);
      chk("hold.dout", 32'(dataout), 32'h20);

      // full + simultaneous write/read
      fill32();
      write = 1; read = 1; datain = 8'hAA;
      step();
      write = 0; read = 0;
      chk("fwr.count", 32'(count), 32);
      chk("fwr.full", 32'(full), 1);
      chk("fwr.dout", 32'(dataout), 32'h01);
      chk("fwr.dvld", 32'(dataout_valid), 1);
      for (int k = 2; k <= 33; k++) begin
         read = 1;
         step();
         chk("fwr.drain", 32'(dataout), (k == 33) ? 32'hAA : 32'(k));
      end
      read = 0;
      chk("fwr.empty", 32'(empty), 1);

      // empty + simultaneous write/read
      write = 1; read = 1; datain = 8'h5C;
      step();
      write = 0; read = 0;
      chk("ewr.count", 32'(count), 1);
      chk("ewr.dvld", 32'(dataout_valid), 0);
      chk("ewr.udf", 32'(underflow), 0);
      chk("ewr.dout_hold", 32'(dataout), 32'hAA);
      read = 1;
      step();
      read = 0;
      chk("ewr.dout", 32'(dataout), 32'h5C);
      chk("ewr.empty", 32'(empty), 1);

      // overflow / underflow
      fill32();
      write = 1; datain = 8'h77;
      step();
      write = 0;
      chk("ovf.set", 32'(overflow), 1);
      chk("ovf.count", 32'(count), 32);
      clr_err = 1;
      step();
      clr_err = 0;
      chk("ovf.clr", 32'(overflow), 0);
      for (int k = 1; k <= 32; k++) begin
         read = 1;
         step();
         chk("ovf.drain", 32'(dataout), 32'(k));
      end
      read = 1;
      step();
      chk("udf.set", 32'(underflow), 1);
      chk("udf.dvld", 32'(dataout_valid), 0);
      chk("udf.dout_hold", 32'(dataout), 32'h20);
      clr_err = 1;
      step();
      chk("udf.clr_vs_new", 32'(underflow), 1);
      read = 0;
      step();
      clr_err = 0;
      chk("udf.clr", 32'(underflow), 0);

      // interleaved traffic crossing the pointer wrap
      exp_cnt = 0; rd_idx = 0; wr_idx = 0;
      for (int i = 0; i < 40; i++) begin
         write = 1; datain = 8'(8'h40 + i); wr_idx++;
         read = i[0];
         rd_acc = read && (exp_cnt > 0);
         step();
         exp_cnt = exp_cnt + 1 - int'(rd_acc);
         chk("wrap.count", 32'(count), 32'(exp_cnt));
         if (rd_acc) begin
            chk("wrap.dout", 32'(dataout), 32'(8'h40 + rd_idx));
            rd_idx++;
         end
      end
      write = 0;
      for (int g = 0; g < 40 && exp_cnt > 0; g++) begin
         read = 1;
         step();
         exp_cnt--;
         chk("wrap.drain", 32'(dataout), 32'(8'h40 + rd_idx));
         chk("wrap.dcount", 32'(count), 32'(exp_cnt));
         rd_idx++;
      end
      read = 0;
      chk("wrap.all_read", 32'(rd_idx), 32'(wr_idx));
      chk("wrap.empty", 32'(empty), 1);

      // flush at count 10
      for (int i = 0; i < 10; i++) begin
         write = 1; datain = 8'(8'h90 + i);
         step();
      end
      chk("fl.pre", 32'(count), 10);
      flush = 1; write = 1; read = 1;
      step();
      flush = 0; write = 0; read = 0;
      chk("fl.count", 32'(count), 0);
      chk("fl.empty", 32'(empty), 1);
      chk("fl.dvld", 32'(dataout_valid), 0);
      chk("fl.dout_hold", 32'(dataout), 32'h67);

      // reset mid-operation at count 5
      for (int i = 0; i < 5; i++) begin
         write = 1; datain = 8'(8'hC0 + i);
         step();
      end
      chk("mr.pre", 32'(count), 5);
      reset = 1; write = 1; read = 1; flush = 1; clr_err = 1;
      step();
      idle();
      chk_reset_state("mr");

      // write accepted in first cycle after reset
      write = 1; datain = 8'h11;
      step();
      write = 0;
      chk("post.count", 32'(count), 1);
      read = 1;
      step();
      read = 0;
      chk("post.dout", 32'(dataout), 32'h11);
      chk("post.empty", 32'(empty), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
